// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory responder: word-addressed RAM behind a req/gnt address phase,
// in-order rvalid/rdata responses a fixed LATENCY cycles after each accept.
module cv32e40p_obi_mem_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          MEM_WORDS       = 1024,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] OOB_RDATA       = 32'hBADC_AB1E
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        stall_i,
  output logic        oob_o,
  output logic        busy_o
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          accept;
  logic [31:0]   resp_data;
  logic          resp_oob;
  logic          tail_v;
  logic [31:0]   tail_d;
  logic          tail_o;
  logic [3:0]    cnt;

  // Offset subtraction wraps, so addresses below BASE_ADDR fall out of range.
  assign offset   = addr_i - BASE_ADDR;
  assign in_range = ({1'b0, offset} < MEM_BYTES);
  assign word_idx = offset[AW+1:2];

  // A response retiring this cycle frees its slot for a same-cycle accept.
  assign gnt_o  = rst_ni & req_i & ~stall_i & ((cnt < 4'(MAX_OUTSTANDING)) | rvalid_o);
  assign accept = req_i & gnt_o;
  assign busy_o = (cnt != 4'd0);

  assign resp_oob  = ~in_range;
  assign resp_data = we_i     ? 32'h0 :
                     in_range ? mem[word_idx] : OOB_RDATA;

  // RAM is deliberately not reset so contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Fixed latency with at most one accept per cycle: a delay line of
  // LATENCY-1 stages feeding the output register keeps responses in order.
  generate
    if (LATENCY == 1) begin : g_direct
      assign tail_v = accept;
      assign tail_d = resp_data;
      assign tail_o = resp_oob;
    end else begin : g_delay
      logic [LATENCY-2:0]       pv;
      logic [LATENCY-2:0]       po;
      logic [LATENCY-2:0][31:0] pd;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          pv <= '0;
          po <= '0;
          pd <= '0;
        end else begin
          pv[0] <= accept;
          po[0] <= resp_oob;
          pd[0] <= resp_data;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pv[i] <= pv[i-1];
            po[i] <= po[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign tail_v = pv[LATENCY-2];
      assign tail_d = pd[LATENCY-2];
      assign tail_o = po[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= 32'h0;
      oob_o    <= 1'b0;
    end else begin
      rvalid_o <= tail_v;
      oob_o    <= tail_v & tail_o;
      if (tail_v) rdata_o <= tail_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= 4'd0;
    end else begin
      case ({accept, rvalid_o})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt <= 4'(MAX_OUTSTANDING));

  // Requester must hold the request and its payload until granted.
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_i && !gnt_o) |=> (req_i && $stable(addr_i) && $stable(we_i)
                           && $stable(be_i) && $stable(wdata_i)));

endmodule
